// File: rtl/branch_predictor_if.sv
// Fetch lookup and resolve-update bundle for the branch predictor.
// Stats outputs exist only when BP_STATS_EN is defined.
interface branch_predictor_if;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
`ifdef BP_STATS_EN
  logic [15:0] branch_cnt_o;
  logic [15:0] mispred_cnt_o;

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    output upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o,
    input  branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    input  upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o,
    output branch_cnt_o, mispred_cnt_o
  );
`else
  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    output upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    input  upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, combinational lookup.
// Optional stats counters enabled by macro BP_STATS_EN.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  branch_predictor_if.slave bp
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [31:0]      tgt_q   [N];
  logic [1:0]       ctr_q   [N];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             pred_taken;
  logic [1:0]       ctr_d;
  logic             mispredict_q, mispredict_d;

  assign rd_idx = bp.pc_i[IDX_W+1:2];
  assign rd_tag = bp.pc_i[31:IDX_W+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign pred_taken       = rd_hit && ctr_q[rd_idx][1];
  assign bp.pred_taken_o  = pred_taken;
  assign bp.pred_target_o = pred_taken ? tgt_q[rd_idx]
                                       : bp.pc_i + 32'd4;

  assign wr_idx = bp.upd_pc_i[IDX_W+1:2];
  assign wr_tag = bp.upd_pc_i[31:IDX_W+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Saturating counter step for the entry being resolved
  always_comb begin
    ctr_d = ctr_q[wr_idx];
    if (bp.upd_taken_i && ctr_q[wr_idx] != 2'b11)
      ctr_d = ctr_q[wr_idx] + 2'b01;
    else if (!bp.upd_taken_i && ctr_q[wr_idx] != 2'b00)
      ctr_d = ctr_q[wr_idx] - 2'b01;
  end

  // Direction or target disagreement with what fetch assumed
  always_comb begin
    mispredict_d = 1'b0;
    if (bp.upd_valid_i)
      mispredict_d =
        (bp.upd_taken_i != bp.upd_pred_taken_i) ||
        (bp.upd_taken_i && bp.upd_pred_taken_i &&
         bp.upd_target_i != bp.upd_pred_target_i);
  end

  // Table update: train on hit, allocate only on taken miss
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bp.upd_valid_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_d;
        if (bp.upd_taken_i)
          tgt_q[wr_idx] <= bp.upd_target_i;
      end else if (bp.upd_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= bp.upd_target_i;
        ctr_q[wr_idx]   <= 2'b10;
      end
    end
  end

  // One-cycle redirect pulse per mispredicted update
  always_ff @(posedge clk_i) begin
    if (rst_i) mispredict_q <= 1'b0;
    else       mispredict_q <= mispredict_d;
  end

  assign bp.mispredict_o = mispredict_q;

`ifdef BP_STATS_EN
  logic [15:0] branch_cnt_q, mispred_cnt_q;

  // Saturating resolved-branch and mispredict counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bp.upd_valid_i) begin
      if (branch_cnt_q != 16'hFFFF)
        branch_cnt_q <= branch_cnt_q + 16'd1;
      if (mispredict_d && mispred_cnt_q != 16'hFFFF)
        mispred_cnt_q <= mispred_cnt_q + 16'd1;
    end
  end

  assign bp.branch_cnt_o  = branch_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table model.
// Define BP_STATS_EN to also check the stats counters.
module tb_branch_predictor;
  localparam int IDX = 4;
  localparam int N   = 1 << IDX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bp_if();

  branch_predictor #(.IDX_W(IDX)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bp(bp_if)
  );

  int checks = 0;
  int failures = 0;

  bit          mv   [N];
  int unsigned mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];
  int unsigned bcnt, mcnt;
  bit          exp_mis;

  function automatic int unsigned ix(logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tg(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
    end
    bcnt = 0; mcnt = 0;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return mv[ix(pc)] && mtag[ix(pc)] == tg(pc);
  endfunction

  function automatic bit m_ptaken(logic [31:0] pc);
    return m_hit(pc) && mctr[ix(pc)] >= 2;
  endfunction

  function automatic logic [31:0] m_ptgt(logic [31:0] pc);
    return m_ptaken(pc) ? mtgt[ix(pc)] : pc + 32'd4;
  endfunction

  function automatic void m_update(logic [31:0] pc, bit t,
                                   logic [31:0] tgt);
    int unsigned k;
    k = ix(pc);
    if (m_hit(pc)) begin
      if (t) begin
        mctr[k] = (mctr[k] == 3) ? 3 : mctr[k] + 1;
        mtgt[k] = tgt;
      end else begin
        mctr[k] = (mctr[k] == 0) ? 0 : mctr[k] - 1;
      end
    end else if (t) begin
      mv[k] = 1; mtag[k] = tg(pc); mtgt[k] = tgt; mctr[k] = 2;
    end
  endfunction

  task automatic drive_upd(bit v, logic [31:0] pc, bit t,
                           logic [31:0] tgt, bit pt,
                           logic [31:0] ptgt);
    bp_if.upd_valid_i       = v;
    bp_if.upd_pc_i          = pc;
    bp_if.upd_taken_i       = t;
    bp_if.upd_target_i      = tgt;
    bp_if.upd_pred_taken_i  = pt;
    bp_if.upd_pred_target_i = ptgt;
  endtask

  // advance one edge; model follows the architectural rules
  task automatic tick();
    bit t, pt;
    logic [31:0] tgt, ptgt;
    @(posedge clk);
    t = bp_if.upd_taken_i; pt = bp_if.upd_pred_taken_i;
    tgt = bp_if.upd_target_i; ptgt = bp_if.upd_pred_target_i;
    exp_mis = 0;
    if (rst) begin
      m_reset();
    end else if (bp_if.upd_valid_i) begin
      exp_mis = (t != pt) || (t && pt && tgt != ptgt);
      if (bcnt < 65535) bcnt++;
      if (exp_mis && mcnt < 65535) mcnt++;
      m_update(bp_if.upd_pc_i, t, tgt);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    bp_if.pc_i = 32'h0040_0010;
    drive_upd(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 0);
    tick();
    tick();
    checks++;
    if (bp_if.mispredict_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mis got=%b exp=0", bp_if.mispredict_o);
    end
    checks++;
    if (bp_if.pred_taken_o !== 1'b0 ||
        bp_if.pred_target_o !== 32'h0040_0014) begin
      failures++;
      $display("FAIL reset_lookup got=%b/%h exp=0/00400014",
               bp_if.pred_taken_o, bp_if.pred_target_o);
    end
`ifdef BP_STATS_EN
    checks++;
    if (bp_if.branch_cnt_o !== 16'd0 ||
        bp_if.mispred_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0",
               bp_if.branch_cnt_o, bp_if.mispred_cnt_o);
    end
`endif
    rst = 0;
    drive_upd(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (bp_if.mispredict_o !== 1'b0 ||
        bp_if.pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_lost_upd got=%b/%b exp=0/0",
               bp_if.mispredict_o, bp_if.pred_taken_o);
    end
  endtask

  task automatic test_alloc();
    bp_if.pc_i = 32'h0040_0010;
    drive_upd(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 0);
    #1;
    checks++;
    if (bp_if.pred_taken_o !== 1'b0 ||
        bp_if.pred_target_o !== 32'h0040_0014) begin
      failures++;
      $display("FAIL same_cycle_nobypass got=%b/%h exp=0/00400014",
               bp_if.pred_taken_o, bp_if.pred_target_o);
    end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (bp_if.mispredict_o !== 1'b1) begin
      failures++;
      $display("FAIL alloc_mis got=%b exp=1", bp_if.mispredict_o);
    end
    checks++;
    if (bp_if.pred_taken_o !== 1'b1 ||
        bp_if.pred_target_o !== 32'h0040_0100) begin
      failures++;
      $display("FAIL alloc_hit got=%b/%h exp=1/00400100",
               bp_if.pred_taken_o, bp_if.pred_target_o);
    end
    tick();
    checks++;
    if (bp_if.mispredict_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_pulse_width got=%b exp=0",
               bp_if.mispredict_o);
    end
  endtask

  task automatic test_counter();
    bit exp_t [5] = '{0, 0, 0, 0, 1};
    bit upd_t [5] = '{0, 0, 0, 1, 1};
    bp_if.pc_i = 32'h0040_0010;
    for (int i = 0; i < 5; i++) begin
      drive_upd(1, 32'h0040_0010, upd_t[i], 32'h0040_0200, 0, 0);
      tick();
      drive_upd(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (bp_if.pred_taken_o !== exp_t[i]) begin
        failures++;
        $display("FAIL counter_step%0d got=%b exp=%b",
                 i, bp_if.pred_taken_o, exp_t[i]);
      end
    end
    checks++;
    if (bp_if.pred_target_o !== 32'h0040_0200) begin
      failures++;
      $display("FAIL counter_target got=%h exp=00400200",
               bp_if.pred_target_o);
    end
  endtask

  task automatic test_alias();
    bp_if.pc_i = 32'h0040_0050;
    #1;
    checks++;
    if (bp_if.pred_taken_o !== 1'b0 ||
        bp_if.pred_target_o !== 32'h0040_0054) begin
      failures++;
      $display("FAIL alias_miss got=%b/%h exp=0/00400054",
               bp_if.pred_taken_o, bp_if.pred_target_o);
    end
    bp_if.pc_i = 32'h0040_0013;
    #1;
    checks++;
    if (bp_if.pred_taken_o !== 1'b1 ||
        bp_if.pred_target_o !== 32'h0040_0200) begin
      failures++;
      $display("FAIL low_bits_ignored got=%b/%h exp=1/00400200",
               bp_if.pred_taken_o, bp_if.pred_target_o);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    rst = 1; drive_upd(0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    drive_upd(1, 32'h0040_0020, 1, 32'h0040_0300, 0, 0);
    tick();
    drive_upd(1, 32'h0040_0020, 1, 32'h0040_0300,
              1, 32'h0040_0300);
    tick();
    drive_upd(1, 32'h0040_0020, 0, 32'h0040_0300, 0, 0);
    tick();
    checks++;
    if (bp_if.branch_cnt_o !== 16'd3 ||
        bp_if.mispred_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL stats_count got=%0d/%0d exp=3/1",
               bp_if.branch_cnt_o, bp_if.mispred_cnt_o);
    end
    rst = 1;
    drive_upd(1, 32'h0040_0020, 1, 32'h0, 0, 0);
    tick();
    rst = 0; drive_upd(0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_if.branch_cnt_o !== 16'd0 ||
        bp_if.mispred_cnt_o !== 16'd0 ||
        bp_if.mispredict_o !== 1'b0) begin
      failures++;
      $display("FAIL stats_reset got=%0d/%0d/%b exp=0/0/0",
               bp_if.branch_cnt_o, bp_if.mispred_cnt_o,
               bp_if.mispredict_o);
    end
  endtask
`endif

  function automatic logic [31:0] rand_pc();
    return 32'h0040_0000 + ($urandom_range(0, 3) << 6)
         + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    logic [31:0] upc, utgt, ptgt;
    bit t, pt, v;
    int lk_fail = 0, mis_fail = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) != 0);
      upc = rand_pc();
      t = $urandom_range(0, 1);
      utgt = 32'h0040_1000 + ($urandom_range(0, 3) << 4);
      if ($urandom_range(0, 3) != 0) begin
        pt = m_ptaken(upc); ptgt = m_ptgt(upc);
      end else begin
        pt = $urandom_range(0, 1);
        ptgt = 32'h0040_1000 + ($urandom_range(0, 3) << 4);
      end
      drive_upd(v, upc, t, utgt, pt, ptgt);
      bp_if.pc_i = rand_pc();
      #1;
      checks++;
      if (bp_if.pred_taken_o !== m_ptaken(bp_if.pc_i) ||
          bp_if.pred_target_o !== m_ptgt(bp_if.pc_i)) begin
        failures++;
        if (lk_fail++ < 5)
          $display("FAIL rand_lookup pc=%h got=%b/%h exp=%b/%h",
                   bp_if.pc_i, bp_if.pred_taken_o,
                   bp_if.pred_target_o, m_ptaken(bp_if.pc_i),
                   m_ptgt(bp_if.pc_i));
      end
      tick();
      checks++;
      if (bp_if.mispredict_o !== exp_mis) begin
        failures++;
        if (mis_fail++ < 5)
          $display("FAIL rand_mis cyc=%0d got=%b exp=%b",
                   c, bp_if.mispredict_o, exp_mis);
      end
`ifdef BP_STATS_EN
      checks++;
      if (bp_if.branch_cnt_o !== bcnt[15:0] ||
          bp_if.mispred_cnt_o !== mcnt[15:0]) begin
        failures++;
        if (mis_fail++ < 5)
          $display("FAIL rand_stats got=%0d/%0d exp=%0d/%0d",
                   bp_if.branch_cnt_o, bp_if.mispred_cnt_o,
                   bcnt, mcnt);
      end
`endif
    end
    rst = 0;
  endtask

  initial begin
    bp_if.pc_i = 0;
    drive_upd(0, 0, 0, 0, 0, 0);
    m_reset();
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
`ifdef BP_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4: index width; table holds 2**IDX_W entries; legal range 2..8.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 pc_i  input  32  fetch-stage PC for lookup.
REQ-005 pred_taken_o  output  1  predicted taken for pc_i.
REQ-006 pred_target_o  output  32  predicted next PC for pc_i.
REQ-007 upd_valid_i  input  1  resolved branch present this cycle.
REQ-008 upd_pc_i  input  32  PC of resolved branch.
REQ-009 upd_taken_i  input  1  actual outcome, driven from branch control enable.
REQ-010 upd_target_i  input  32  actual branch target.
REQ-011 upd_pred_taken_i  input  1  prediction carried down the pipe with this branch.
REQ-012 upd_pred_target_i  input  32  predicted target carried down the pipe.
REQ-013 mispredict_o  output  1  registered mispredict flag for fetch redirect.
REQ-014 branch_cnt_o  output  16  resolved-branch count (BP_STATS_EN only).
REQ-015 mispred_cnt_o  output  16  mispredict count (BP_STATS_EN only).

Function
REQ-016 Each entry: valid bit, tag = PC[31:2+IDX_W], 32-bit target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-017 Index = PC[IDX_W+1:2]; PC[1:0] ignored.
REQ-018 Lookup purely combinational: hit = valid and tag match.
REQ-019 Hit and counter[1]=1 -> pred_taken_o=1, pred_target_o=stored target; otherwise pred_taken_o=0, pred_target_o=pc_i+4 (mod 2**32).
REQ-020 Update on clock edge when upd_valid_i=1; no action when 0.
REQ-021 Update hit: counter increments (saturate at 11) if taken, decrements (saturate at 00) if not taken; target overwritten with upd_target_i only if taken.
REQ-022 Update miss and taken: allocate/replace entry, valid=1, tag written, target=upd_target_i, counter=10.
REQ-023 Update miss and not taken: table unchanged.
REQ-024 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass); new value visible next cycle.
REQ-025 mispredict_o, one cycle after upd_valid_i=1: 1 if upd_taken_i!=upd_pred_taken_i, or both taken and upd_target_i!=upd_pred_target_i; else 0.
REQ-026 mispredict_o=0 in any cycle following upd_valid_i=0; pulse width exactly one cycle per mispredicted update.

Reset
REQ-027 rst_i=1 at clock edge: all valid bits 0, all counters 01, targets 0, mispredict_o 0, counters (if present) 0.
REQ-028 Reset overrides a simultaneous update; that update is lost and no mispredict pulse follows.
REQ-029 During and after reset every lookup misses: pred_taken_o=0, pred_target_o=pc_i+4.

Configuration
REQ-030 Macro BP_STATS_EN defined: branch_cnt_o increments on every upd_valid_i=1; mispred_cnt_o increments when mispredict condition of REQ-025 holds; both saturate at 16'hFFFF, registered, same-edge as mispredict_o.
REQ-031 BP_STATS_EN undefined: branch_cnt_o and mispred_cnt_o ports absent; no stats logic; all other behaviour identical.

Verification
REQ-032 Reset, pc_i=0x00400010 -> pred_taken_o=0, pred_target_o=0x00400014.
REQ-033 Update pc=0x00400010 taken target 0x00400100, pred_taken=0 -> next cycle mispredict_o=1; lookup 0x00400010 -> taken, 0x00400100.
REQ-034 Same PC: two not-taken updates -> counter 10->01->00; lookup predicts not taken; third not-taken holds 00; two taken updates needed to predict taken again.
REQ-035 IDX_W=4: entry for 0x00400010 allocated, then lookup 0x00400050 (same index, different tag) -> miss, pred_target_o=0x00400054.
REQ-036 Same-cycle update and lookup of 0x00400010 after reset -> lookup shows miss that cycle, hit next cycle.
REQ-037 BP_STATS_EN: 3 updates, 1 mispredicted -> branch_cnt_o=3, mispred_cnt_o=1; rst_i asserted with upd_valid_i=1 -> both 0, mispredict_o=0.
